// File: rtl/cmd_dispatch.sv
// rtl/cmd_dispatch.sv - command decoder/dispatcher; optional SPI wait timeout via CMD_TIMEOUT_EN
module cmd_dispatch #(
    parameter int NUM_CH     = 3,
    parameter int TRIG_POS_W = 9,
    parameter int DEC_W      = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [23:0]           cmd,
    input  logic                  cmd_rdy,
    output logic                  clr_cmd_rdy,
    output logic                  wrt_SPI,
    output logic [15:0]           SPI_data,
    output logic [NUM_CH:0]       ss,
    input  logic                  SPI_done,
    input  logic [7:0]            EEP_data,
    output logic [7:0]            resp_data,
    output logic                  send_resp,
    input  logic                  resp_sent,
    output logic                  dump_en,
    output logic [1:0]            dump_chan,
    output logic [7:0]            trig_cfg,
    output logic [TRIG_POS_W-1:0] trig_pos,
    output logic [DEC_W-1:0]      decimator,
    output logic [3*NUM_CH-1:0]   gain
);
    typedef enum logic [2:0] {IDLE, DECODE, SPI_WAIT, RESP, WAIT_SENT} state_t;

    localparam logic [2:0] NUM_CH_L = 3'(NUM_CH);

    state_t                state_q, state_d;
    logic [23:0]           cmd_q, cmd_d;
    logic [7:0]            resp_q, resp_d;
    logic                  clr_q, clr_d;
    logic [1:0]            dump_chan_q, dump_chan_d;
    logic [5:0]            trig_cfg_q, trig_cfg_d;
    logic [TRIG_POS_W-1:0] trig_pos_q, trig_pos_d;
    logic [DEC_W-1:0]      dec_q, dec_d;
    logic [3*NUM_CH-1:0]   gain_q, gain_d;

    logic [7:0]      opc, arg1, arg2, lvl;
    logic [1:0]      cc;
    logic [2:0]      ggg, gain_sel;
    logic            cc_ok, spi_op, spi_active;
    logic [15:0]     spi_word, pos_word;
    logic [NUM_CH:0] ss_sel;

`ifdef CMD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign opc      = cmd_q[23:16];
    assign arg1     = cmd_q[15:8];
    assign arg2     = cmd_q[7:0];
    assign cc       = arg1[1:0];
    assign ggg      = arg1[4:2];
    assign cc_ok    = {1'b0, cc} < NUM_CH_L;
    assign pos_word = cmd_q[15:0];

    function automatic logic [7:0] gain_code(input logic [2:0] g);
        case (g)
            3'd0:    return 8'h02;
            3'd1:    return 8'h05;
            3'd2:    return 8'h09;
            3'd3:    return 8'h14;
            3'd4:    return 8'h28;
            3'd5:    return 8'h46;
            3'd6:    return 8'h6B;
            default: return 8'hDD;
        endcase
    endfunction

    // SPI word and slave select derive purely from the latched command, so they stay stable through SPI_WAIT
    always_comb begin
        gain_sel = 3'd0;
        ss_sel   = '0;
        spi_op   = 1'b0;
        spi_word = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (cc == 2'(n)) begin
                gain_sel = gain_q[3*n +: 3];
            end
        end
        lvl = (arg2 < 8'd46) ? 8'd46 : ((arg2 > 8'd201) ? 8'd201 : arg2);
        case (opc)
            8'h02: begin
                spi_op   = cc_ok;
                spi_word = {8'h13, gain_code(ggg)};
                for (int n = 0; n < NUM_CH; n++) begin
                    if (cc == 2'(n)) begin
                        ss_sel[n] = 1'b1;
                    end
                end
            end
            8'h03: begin
                spi_op    = 1'b1;
                spi_word  = {8'h13, lvl};
                ss_sel[0] = 1'b1;
            end
            8'h08: begin
                spi_op         = 1'b1;
                spi_word       = {2'b01, arg1[5:0], arg2};
                ss_sel[NUM_CH] = 1'b1;
            end
            8'h09: begin
                spi_op         = 1'b1;
                spi_word       = {2'b00, arg1[5:0], 8'h00};
                ss_sel[NUM_CH] = 1'b1;
            end
            default: ;
        endcase
    end

    assign spi_active  = ((state_q == DECODE) || (state_q == SPI_WAIT)) && spi_op;
    assign SPI_data    = spi_active ? spi_word : '0;
    assign ss          = spi_active ? ss_sel : '0;
    assign wrt_SPI     = (state_q == DECODE) && spi_op;
    assign dump_en     = (state_q == DECODE) && (opc == 8'h01) && cc_ok;
    assign send_resp   = (state_q == RESP);
    assign clr_cmd_rdy = clr_q;
    assign resp_data   = resp_q;
    assign dump_chan   = dump_chan_q;
    assign trig_cfg    = {2'b00, trig_cfg_q};
    assign trig_pos    = trig_pos_q;
    assign decimator   = dec_q;
    assign gain        = gain_q;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        resp_d      = resp_q;
        clr_d       = 1'b0;
        dump_chan_d = dump_chan_q;
        trig_cfg_d  = trig_cfg_q;
        trig_pos_d  = trig_pos_q;
        dec_d       = dec_q;
        gain_d      = gain_q;
`ifdef CMD_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_rdy) begin
                    cmd_d   = cmd;
                    clr_d   = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                state_d = RESP;
                resp_d  = 8'hA5;
`ifdef CMD_TIMEOUT_EN
                cnt_d   = '0;
`endif
                case (opc)
                    8'h01: if (cc_ok) dump_chan_d = cc; else resp_d = 8'hEE;
                    8'h02: begin
                        if (cc_ok) begin
                            state_d = SPI_WAIT;
                            for (int n = 0; n < NUM_CH; n++) begin
                                if (cc == 2'(n)) begin
                                    gain_d[3*n +: 3] = ggg;
                                end
                            end
                        end else begin
                            resp_d = 8'hEE;
                        end
                    end
                    8'h03, 8'h08, 8'h09: state_d = SPI_WAIT;
                    8'h04: trig_pos_d = pos_word[TRIG_POS_W-1:0];
                    8'h05: dec_d = arg2[DEC_W-1:0];
                    8'h06: trig_cfg_d = arg1[5:0];
                    8'h07: resp_d = {2'b00, trig_cfg_q};
                    8'h0A: resp_d = cc_ok ? {5'b0, gain_sel} : 8'hEE;
                    default: resp_d = 8'hEE;
                endcase
            end
            SPI_WAIT: begin
                if (SPI_done) begin
                    resp_d  = (opc == 8'h09) ? EEP_data : 8'hA5;
                    state_d = RESP;
                end
`ifdef CMD_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    resp_d  = 8'hEF;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: state_d = WAIT_SENT;
            WAIT_SENT: if (resp_sent) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            resp_q      <= '0;
            clr_q       <= 1'b0;
            dump_chan_q <= '0;
            trig_cfg_q  <= '0;
            trig_pos_q  <= '0;
            dec_q       <= '0;
            gain_q      <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            resp_q      <= resp_d;
            clr_q       <= clr_d;
            dump_chan_q <= dump_chan_d;
            trig_cfg_q  <= trig_cfg_d;
            trig_pos_q  <= trig_pos_d;
            dec_q       <= dec_d;
            gain_q      <= gain_d;
        end
    end

`ifdef CMD_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif
endmodule

// File: tb/tb_cmd_dispatch.sv
// tb/tb_cmd_dispatch.sv - self-checking bench for cmd_dispatch with a behavioural command model
module tb_cmd_dispatch;
    localparam int NUM_CH     = 3;
    localparam int TRIG_POS_W = 9;
    localparam int DEC_W      = 4;
    localparam int TIMEOUT    = 1023;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [23:0]           cmd;
    logic                  cmd_rdy;
    logic                  clr_cmd_rdy;
    logic                  wrt_SPI;
    logic [15:0]           SPI_data;
    logic [NUM_CH:0]       ss;
    logic                  SPI_done;
    logic [7:0]            EEP_data;
    logic [7:0]            resp_data;
    logic                  send_resp;
    logic                  resp_sent;
    logic                  dump_en;
    logic [1:0]            dump_chan;
    logic [7:0]            trig_cfg;
    logic [TRIG_POS_W-1:0] trig_pos;
    logic [DEC_W-1:0]      decimator;
    logic [3*NUM_CH-1:0]   gain;

    int total = 0;
    int bad   = 0;

    int m_gain[4];
    int m_tcfg, m_tpos, m_dec, m_dchan;
    int gtab[8] = '{8'h02, 8'h05, 8'h09, 8'h14, 8'h28, 8'h46, 8'h6B, 8'hDD};

    cmd_dispatch #(
        .NUM_CH(NUM_CH), .TRIG_POS_W(TRIG_POS_W), .DEC_W(DEC_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
        .wrt_SPI(wrt_SPI), .SPI_data(SPI_data), .ss(ss), .SPI_done(SPI_done),
        .EEP_data(EEP_data), .resp_data(resp_data), .send_resp(send_resp),
        .resp_sent(resp_sent), .dump_en(dump_en), .dump_chan(dump_chan),
        .trig_cfg(trig_cfg), .trig_pos(trig_pos), .decimator(decimator), .gain(gain)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 4; n++) m_gain[n] = 0;
        m_tcfg = 0; m_tpos = 0; m_dec = 0; m_dchan = 0;
    endtask

    // Reference behaviour: what one command should do, computed from the command rules directly
    task automatic model(input logic [23:0] c, input logic [7:0] eep, output logic spi,
                         output logic [15:0] word, output logic [3:0] ssx,
                         output logic dmp, output logic [7:0] rsp);
        int op, a1, a2, cc, g, lvl;
        op = int'(c[23:16]); a1 = int'(c[15:8]); a2 = int'(c[7:0]);
        cc = a1 % 4; g = (a1 / 4) % 8;
        spi = 1'b0; word = 16'h0; ssx = 4'h0; dmp = 1'b0; rsp = 8'hA5;
        case (op)
            1: if (cc < NUM_CH) begin dmp = 1'b1; m_dchan = cc; end else rsp = 8'hEE;
            2: if (cc < NUM_CH) begin
                   m_gain[cc] = g; spi = 1'b1;
                   word = 16'(16'h1300 + gtab[g]); ssx = 4'(1 << cc);
               end else rsp = 8'hEE;
            3: begin
                   lvl = (a2 < 46) ? 46 : ((a2 > 201) ? 201 : a2);
                   spi = 1'b1; word = 16'(16'h1300 + lvl); ssx = 4'h1;
               end
            4: m_tpos = (a1 * 256 + a2) % (1 << TRIG_POS_W);
            5: m_dec = a2 % (1 << DEC_W);
            6: m_tcfg = a1 % 64;
            7: rsp = 8'(m_tcfg);
            8: begin spi = 1'b1; word = 16'(16'h4000 + (a1 % 64) * 256 + a2); ssx = 4'(1 << NUM_CH); end
            9: begin spi = 1'b1; word = 16'((a1 % 64) * 256); ssx = 4'(1 << NUM_CH); rsp = eep; end
            10: rsp = (cc < NUM_CH) ? 8'(m_gain[cc]) : 8'hEE;
            default: rsp = 8'hEE;
        endcase
    endtask

    task automatic chk_cfg();
        int eg;
        eg = 0;
        for (int n = 0; n < NUM_CH; n++) eg += m_gain[n] * (8 ** n);
        chk("gain", 32'(gain), eg);
        chk("trig_cfg", 32'(trig_cfg), m_tcfg);
        chk("trig_pos", 32'(trig_pos), m_tpos);
        chk("decimator", 32'(decimator), m_dec);
        chk("dump_chan", 32'(dump_chan), m_dchan);
    endtask

    task automatic chk_zero();
        chk("rst_clr_cmd_rdy", 32'(clr_cmd_rdy), 0);
        chk("rst_wrt_SPI", 32'(wrt_SPI), 0);
        chk("rst_SPI_data", 32'(SPI_data), 0);
        chk("rst_ss", 32'(ss), 0);
        chk("rst_resp_data", 32'(resp_data), 0);
        chk("rst_send_resp", 32'(send_resp), 0);
        chk("rst_dump_en", 32'(dump_en), 0);
        chk("rst_trig_cfg", 32'(trig_cfg), 0);
        chk("rst_trig_pos", 32'(trig_pos), 0);
        chk("rst_decimator", 32'(decimator), 0);
        chk("rst_gain", 32'(gain), 0);
    endtask

    task automatic do_cmd(input logic [23:0] c, input int dly, input logic [7:0] eep);
        logic spi, dmp;
        logic [15:0] word;
        logic [3:0] ssx;
        logic [7:0] rsp;
        model(c, eep, spi, word, ssx, dmp, rsp);
        cmd = c; cmd_rdy = 1'b1;
        step();
        cmd_rdy = 1'b0;
        chk("clr_cmd_rdy", 32'(clr_cmd_rdy), 1);
        chk("wrt_SPI", 32'(wrt_SPI), 32'(spi));
        chk("dump_en", 32'(dump_en), 32'(dmp));
        chk("ss_decode", 32'(ss), 32'(ssx));
        chk("SPI_data_decode", 32'(SPI_data), 32'(word));
        if (spi) begin
            step();
            for (int k = 0; k <= dly; k++) begin
                if (k > 0) step();
                chk("wrt_SPI_wait", 32'(wrt_SPI), 0);
                chk("ss_wait", 32'(ss), 32'(ssx));
                chk("SPI_data_wait", 32'(SPI_data), 32'(word));
                chk("send_resp_wait", 32'(send_resp), 0);
            end
            SPI_done = 1'b1; EEP_data = eep;
            step();
            SPI_done = 1'b0; EEP_data = 8'($urandom);
        end else begin
            step();
        end
        chk("send_resp", 32'(send_resp), 1);
        chk("resp_data", 32'(resp_data), 32'(rsp));
        chk("ss_resp", 32'(ss), 0);
        step();
        chk("send_resp_once", 32'(send_resp), 0);
        chk("resp_data_held", 32'(resp_data), 32'(rsp));
        cmd = 24'($urandom); cmd_rdy = 1'b1;
        step();
        chk("cmd_ignored", 32'(clr_cmd_rdy), 0);
        cmd_rdy = 1'b0; resp_sent = 1'b1;
        step();
        resp_sent = 1'b0;
        chk_cfg();
    endtask

    initial begin
        int ops[11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0};
        int op, n;
        rst = 1'b1; cmd = '0; cmd_rdy = 1'b0; SPI_done = 1'b0; EEP_data = '0; resp_sent = 1'b0;
        model_reset();
        repeat (3) step();
        rst = 1'b0;
        chk_zero();

        do_cmd(24'h020E00, 5, 8'h00);
        do_cmd(24'h030010, 1, 8'h00);
        do_cmd(24'h0300FF, 0, 8'h00);
        do_cmd(24'h091500, 2, 8'h5A);
        do_cmd(24'h010300, 0, 8'h00);
        do_cmd(24'h110000, 0, 8'h00);
        do_cmd(24'h010200, 0, 8'h00);
        do_cmd(24'h0401AB, 0, 8'h00);
        do_cmd(24'h0500F7, 0, 8'h00);
        do_cmd(24'h06FF00, 0, 8'h00);
        do_cmd(24'h070000, 0, 8'h00);
        do_cmd(24'h0A0200, 0, 8'h00);
        do_cmd(24'h0A0300, 0, 8'h00);

`ifdef CMD_TIMEOUT_EN
        cmd = 24'h080102; cmd_rdy = 1'b1;
        step();
        cmd_rdy = 1'b0;
        n = 0;
        while (!send_resp && n < TIMEOUT + 20) begin
            step();
            n++;
        end
        chk("timeout_latency", n, TIMEOUT + 2);
        chk("timeout_resp", 32'(resp_data), 8'hEF);
        chk("timeout_ss", 32'(ss), 0);
        step();
        resp_sent = 1'b1;
        step();
        resp_sent = 1'b0;
`else
        do_cmd(24'h080102, TIMEOUT + 20, 8'h00);
`endif

        // Abort from SPI_WAIT; a late SPI_done/resp_sent must not produce a response
        cmd = 24'h080102; cmd_rdy = 1'b1;
        step();
        cmd_rdy = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        chk_zero();
        SPI_done = 1'b1; resp_sent = 1'b1;
        step();
        SPI_done = 1'b0; resp_sent = 1'b0;
        n = 0;
        repeat (4) begin
            step();
            n += int'(send_resp);
        end
        chk("abort_no_resp", n, 0);

        do_cmd(24'h060500, 0, 8'h00);
        do_cmd(24'h0500FF, 0, 8'h00);
        cmd = 24'h061200; cmd_rdy = 1'b1;
        step();
        cmd_rdy = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        chk_zero();
        resp_sent = 1'b1;
        step();
        resp_sent = 1'b0;
        chk("post_rst_send_resp", 32'(send_resp), 0);
        do_cmd(24'h060300, 0, 8'h00);

        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 10)];
            if (op == 0) op = $urandom_range(0, 255);
            do_cmd({8'(op), 8'($urandom), 8'($urandom)}, $urandom_range(0, 4), 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cmd_dispatch.md
CMD_DISPATCH -- requirements
Module: cmd_dispatch

Interface
REQ-001 Parameter NUM_CH, default 3: number of analog channels, legal range 1..4.
REQ-002 Parameter TRIG_POS_W, default 9: trig_pos width.
REQ-003 Parameter DEC_W, default 4: decimator width, legal range 1..8.
REQ-004 Parameter TIMEOUT, default 1023: SPI wait limit in clk cycles.
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  system clock, all logic on rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 cmd  in  24  command: opcode [23:16], arg1 [15:8], arg2 [7:0].
REQ-009 cmd_rdy  in  1  command valid; clr_cmd_rdy  out  1  one-cycle acknowledge.
REQ-010 wrt_SPI  out  1  SPI start pulse; SPI_data  out  16  SPI word; ss  out  NUM_CH+1  one-hot select, bit NUM_CH = EEPROM.
REQ-011 SPI_done  in  1  SPI transfer complete; EEP_data  in  8  EEPROM read data.
REQ-012 resp_data  out  8  response byte; send_resp  out  1  one-cycle pulse; resp_sent  in  1  UART done.
REQ-013 dump_en  out  1  pulse; dump_chan  out  2; trig_cfg  out  8; trig_pos  out  TRIG_POS_W; decimator  out  DEC_W; gain  out  3*NUM_CH  per-channel gain, channel n at [3n+2:3n].

Function
REQ-014 FSM states: IDLE, DECODE, SPI_WAIT, RESP, WAIT_SENT.
REQ-015 IDLE: on cmd_rdy, latch cmd, pulse clr_cmd_rdy, go DECODE next cycle.
REQ-016 Opcode compare is exact 8-bit; unlisted opcode -> resp 8'hEE, no side effects.
REQ-017 Channel field cc = arg1[1:0]; cc >= NUM_CH -> resp 8'hEE, no side effects, no SPI.
REQ-018 01 dump: dump_chan <= cc, dump_en pulse in DECODE, resp 8'hA5.
REQ-019 02 gain: ggg = arg1[4:2]; gain[cc] <= ggg; SPI_data = 16'h13 & {02,05,09,14,28,46,6B,DD}[ggg]; ss bit cc.
REQ-020 03 trig level: SPI_data = {8'h13, arg2 saturated to 46..201}; ss bit 0.
REQ-021 04: trig_pos <= low TRIG_POS_W bits of {arg1,arg2}; 05: decimator <= arg2[DEC_W-1:0]; 06: trig_cfg[5:0] <= arg1[5:0]. Each resp 8'hA5.
REQ-022 07: resp {2'b00, trig_cfg[5:0]}; 0A: resp {5'b0, gain[cc]}.
REQ-023 08 EEPROM write: SPI_data = {2'b01, arg1[5:0], arg2}; 09 read: {2'b00, arg1[5:0], 8'h00}; ss bit NUM_CH.
REQ-024 SPI opcodes (02, 03, 08, 09): wrt_SPI pulse in DECODE, then SPI_WAIT; ss and SPI_data held until SPI_WAIT exits.
REQ-025 SPI_WAIT on SPI_done: resp EEP_data for 09, else 8'hA5; go RESP.
REQ-026 RESP: send_resp high exactly one cycle with resp_data stable; go WAIT_SENT.
REQ-027 WAIT_SENT: resp_data held; on resp_sent go IDLE; cmd_rdy ignored until IDLE.
REQ-028 Minimum latency cmd_rdy -> send_resp is 2 cycles for non-SPI opcodes.
REQ-029 trig_cfg[7:6] always 0; ss all-zero outside SPI_WAIT and DECODE.

Reset
REQ-030 rst forces IDLE and zeroes every output and register, including trig_cfg, trig_pos, decimator, gain, resp_data, ss, and pulses.
REQ-031 rst mid-transaction aborts with no response; pending SPI_done or resp_sent afterwards is ignored.

Configuration
REQ-032 Macro CMD_TIMEOUT_EN defined: counter runs in SPI_WAIT; after TIMEOUT cycles without SPI_done, resp 8'hEF, go RESP, ss cleared.
REQ-033 Macro CMD_TIMEOUT_EN undefined: no counter; SPI_WAIT waits indefinitely.

Verification
REQ-034 cmd 24'h020E00 (ch2, gain 3), SPI_done after 5 cycles -> wrt_SPI pulse, SPI_data 16'h1314, ss 4'b0100, gain[8:6]=3, resp 8'hA5.
REQ-035 cmd 24'h030010 -> SPI_data 16'h132E; cmd 24'h0300FF -> SPI_data 16'h13C9.
REQ-036 cmd 24'h091500, SPI_done with EEP_data 8'h5A -> SPI_data 16'h1500, ss 4'b1000, resp 8'h5A.
REQ-037 cmd 24'h010300 (cc=3, NUM_CH=3) -> resp 8'hEE, dump_en low; opcode 8'h11 -> resp 8'hEE.
REQ-038 CMD_TIMEOUT_EN, cmd 24'h080102 without SPI_done -> send_resp at TIMEOUT+2 cycles after DECODE, resp 8'hEF.
REQ-039 rst during WAIT_SENT -> IDLE next cycle, all outputs 0; following cmd 24'h060300 -> trig_cfg 8'h03.
